// File: rtl/bp_pkg.sv
// Shared counter-encoding constants and helper functions for the n-bit branch predictor.
package bp_pkg;

    localparam int unsigned MaxCtrW = 8;

    typedef logic [MaxCtrW-1:0] ctr_word_t;

    function automatic ctr_word_t ctr_max(input int unsigned w);
        return ctr_word_t'((1 << w) - 1);
    endfunction

    // Weakly-not-taken: one below the taken threshold; a 1-bit counter just resets to 0.
    function automatic ctr_word_t weak_nt_init(input int unsigned w);
        if (w <= 1) begin
            return '0;
        end
        return ctr_word_t'((1 << (w - 1)) - 1);
    endfunction

    function automatic ctr_word_t sat_inc(input ctr_word_t v, input int unsigned w);
        return (v >= ctr_max(w)) ? v : v + ctr_word_t'(1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr_next.sv
// Combinational next-state for one saturating prediction counter.
module bp_sat_ctr_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    ctr_word_t cur_w;
    ctr_word_t inc_w;
    logic [CTR_W-1:0] dec;

    always_comb begin
        cur_w = '0;
        cur_w[CTR_W-1:0] = cur;
        inc_w = sat_inc(cur_w, CTR_W);
        dec   = (cur == '0) ? cur : cur - CTR_W'(1);
        nxt   = taken ? inc_w[CTR_W-1:0] : dec;
    end

endmodule

// File: rtl/nbit_predictor.sv
// Table of saturating counters predicting branch outcomes, with lookup/mismatch statistics.
// Define NBIT_PREDICTOR_GSHARE_EN to index the table by branchnumber XOR global history.
module nbit_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CTR_W = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [IDX_W-1:0] branchnumber,
    input  logic             in,
    input  logic             clear_stats,
    output logic             pred_valid,
    output logic             predict,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [CNT_W-1:0] mismatch,
    output logic [CNT_W-1:0] lookups
);

    localparam int unsigned Depth = 2 ** IDX_W;
    localparam ctr_word_t InitWord = weak_nt_init(CTR_W);
    localparam logic [CTR_W-1:0] InitVal = InitWord[CTR_W-1:0];
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CTR_W-1:0] table_q [Depth];
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] cur_ctr;
    logic [CTR_W-1:0] nxt_ctr;
    logic             cur_pred;

    logic             pred_valid_q;
    logic             predict_q;
    logic [CTR_W-1:0] pred_ctr_q;
    logic [CNT_W-1:0] mismatch_q;
    logic [CNT_W-1:0] lookups_q;

`ifdef NBIT_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (valid) begin
            ghr_q <= (ghr_q << 1) | IDX_W'(in);
        end
    end

    assign idx = branchnumber ^ ghr_q;
`else
    assign idx = branchnumber;
`endif

    assign cur_ctr  = table_q[idx];
    assign cur_pred = cur_ctr[CTR_W-1];

    bp_sat_ctr_next #(
        .CTR_W (CTR_W)
    ) u_ctr_next (
        .cur   (cur_ctr),
        .taken (in),
        .nxt   (nxt_ctr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                table_q[i] <= InitVal;
            end
        end else if (valid) begin
            table_q[idx] <= nxt_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            predict_q    <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= valid;
            if (valid) begin
                predict_q  <= cur_pred;
                pred_ctr_q <= cur_ctr;
            end
        end
    end

    // A clear wins over the access that arrives with it, so that access is not counted.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            mismatch_q <= '0;
            lookups_q  <= '0;
        end else if (valid) begin
            if (lookups_q != CntMax) begin
                lookups_q <= lookups_q + CNT_W'(1);
            end
            if (cur_pred != in && mismatch_q != CntMax) begin
                mismatch_q <= mismatch_q + CNT_W'(1);
            end
        end
    end

    assign pred_valid = pred_valid_q;
    assign predict    = predict_q;
    assign pred_ctr   = pred_ctr_q;
    assign mismatch   = mismatch_q;
    assign lookups    = lookups_q;

endmodule

// File: tb/tb_nbit_predictor.sv
// Directed plus randomized checks of nbit_predictor against a behavioural reference model.
module tb_nbit_predictor;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CTR_W = 2;
    localparam int unsigned CNT_W = 32;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CMAX = (1 << CTR_W) - 1;
    localparam int INIT = (CTR_W == 1) ? 0 : (1 << (CTR_W - 1)) - 1;
    localparam longint SMAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic [IDX_W-1:0] branchnumber = '0;
    logic             in = 1'b0;
    logic             clear_stats = 1'b0;
    logic             pred_valid;
    logic             predict;
    logic [CTR_W-1:0] pred_ctr;
    logic [CNT_W-1:0] mismatch;
    logic [CNT_W-1:0] lookups;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_tbl [DEPTH];
    int     m_ghr;
    logic   m_pv;
    logic   m_pp;
    int     m_pc;
    longint m_mm;
    longint m_lk;

    nbit_predictor #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .branchnumber (branchnumber),
        .in           (in),
        .clear_stats  (clear_stats),
        .pred_valid   (pred_valid),
        .predict      (predict),
        .pred_ctr     (pred_ctr),
        .mismatch     (mismatch),
        .lookups      (lookups)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input int b, input logic t,
                         input logic c);
        int i;
        int cv;
        if (r) begin
            for (int k = 0; k < DEPTH; k++) m_tbl[k] = INIT;
            m_ghr = 0; m_pv = 0; m_pp = 0; m_pc = 0; m_mm = 0; m_lk = 0;
            return;
        end
        m_pv = v;
        if (v) begin
`ifdef NBIT_PREDICTOR_GSHARE_EN
            i = (b ^ m_ghr) % DEPTH;
            m_ghr = ((m_ghr * 2) + int'(t)) % DEPTH;
`else
            i = b;
`endif
            cv = m_tbl[i];
            m_pc = cv;
            m_pp = (cv >= (CMAX + 1) / 2);
            m_tbl[i] = t ? ((cv + 1 > CMAX) ? CMAX : cv + 1) : ((cv == 0) ? 0 : cv - 1);
            if (!c) begin
                if (m_lk < SMAX) m_lk++;
                if (m_pp != t && m_mm < SMAX) m_mm++;
            end
        end
        if (c) begin
            m_mm = 0;
            m_lk = 0;
        end
    endtask

    task automatic step(input logic r, input logic v, input int b, input logic t,
                        input logic c);
        reset = r; valid = v; branchnumber = IDX_W'(b); in = t; clear_stats = c;
        @(posedge clk);
        #1;
        model(r, v, b, t, c);
        check("pred_valid", longint'(pred_valid), longint'(m_pv));
        check("predict", longint'(predict), longint'(m_pp));
        check("pred_ctr", longint'(pred_ctr), longint'(m_pc));
        check("mismatch", longint'(mismatch), m_mm);
        check("lookups", longint'(lookups), m_lk);
        reset = 0; valid = 0; clear_stats = 0;
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_lookups", longint'(lookups), 0);

`ifndef NBIT_PREDICTOR_GSHARE_EN
        // idx 3 taken x3: reads 1,2,3 predicting 0,1,1
        step(0, 1, 3, 1, 0);
        check("i3_ctr0", longint'(pred_ctr), 1);
        check("i3_pred0", longint'(predict), 0);
        step(0, 1, 3, 1, 0);
        check("i3_ctr1", longint'(pred_ctr), 2);
        step(0, 1, 3, 1, 0);
        check("i3_ctr2", longint'(pred_ctr), 3);
        check("i3_pred2", longint'(predict), 1);
        check("i3_mismatch", longint'(mismatch), 1);
        check("i3_lookups", longint'(lookups), 3);
        step(0, 0, 3, 0, 0);
        check("idle_pv", longint'(pred_valid), 0);
        check("idle_hold", longint'(pred_ctr), 3);

        // idx 5 saturation then a not-taken
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 5, 1, 0);
        check("i5_sat", longint'(pred_ctr), 3);
        step(0, 1, 5, 0, 0);
        check("i5_nt_ctr", longint'(pred_ctr), 3);
        check("i5_nt_pred", longint'(predict), 1);
        check("i5_mismatch", longint'(mismatch), 2);
        step(0, 1, 5, 0, 0);
        check("i5_after_dec", longint'(pred_ctr), 2);

        // valid during reset is discarded
        step(1, 1, 7, 1, 0);
        check("rst_valid_pv", longint'(pred_valid), 0);
        step(0, 1, 7, 1, 0);
        check("rst_valid_ctr", longint'(pred_ctr), 1);

        // interleaved independent entries
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0);
        check("il_2a", longint'(pred_ctr), 1);
        step(0, 1, 9, 1, 0);
        check("il_9a", longint'(pred_ctr), 1);
        step(0, 1, 2, 1, 0);
        check("il_2b", longint'(pred_ctr), 2);
        step(0, 1, 9, 1, 0);
        check("il_9b", longint'(pred_ctr), 2);

        // clear_stats with a simultaneous access
        step(1, 0, 0, 0, 0);
        for (int k = 10; k < 14; k++) step(0, 1, k, 1, 0);
        check("clr_pre_mm", longint'(mismatch), 4);
        step(0, 1, 10, 1, 1);
        check("clr_mm", longint'(mismatch), 0);
        check("clr_lk", longint'(lookups), 0);
        check("clr_ctr", longint'(pred_ctr), 2);
        step(0, 1, 10, 1, 0);
        check("clr_tbl_upd", longint'(pred_ctr), 3);
`else
        // gshare: history 0, outcomes 1,1 on branch 0 -> second access hits index 1
        step(0, 1, 0, 1, 0);
        check("gs_first", longint'(pred_ctr), 1);
        step(0, 1, 0, 1, 0);
        check("gs_second", longint'(pred_ctr), 1);
        step(0, 1, 1, 1, 0);
        check("gs_third", longint'(pred_ctr), 1);
`endif

        // Randomized traffic against the model
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 70),
                 int'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 99) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
